// File: rtl/i2c_reg_bridge.sv
// Register-file bridge behind an I2C byte-level slave: pointer-addressed RW config
// registers committed atomically on STOP, plus a read-only status bank snapshotted per read.
module i2c_reg_bridge #(
  parameter int unsigned NREG    = 16,
  parameter int unsigned RO_BASE = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            scl,
  input  logic                            sda_i,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_ena,
  input  logic                            bus_ready,
  output logic [7:0]                      tx_data,
  input  logic                            tx_rdreq,
  output logic [RO_BASE*8-1:0]            cfg_out,
  input  logic [(NREG-RO_BASE)*8-1:0]     status_in,
  output logic                            cfg_update,
  output logic                            wr_stb,
  output logic [$clog2(NREG)-1:0]         wr_addr,
  output logic                            busy
);

  localparam int unsigned AW    = $clog2(NREG);
  localparam int unsigned AW1   = AW + 1;
  localparam int unsigned NSTAT = NREG - RO_BASE;
  localparam int unsigned CW    = RO_BASE * 8;
  localparam int unsigned SW    = NSTAT * 8;
  localparam logic [AW:0] RO_LIM = AW1'(RO_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEV,
    S_PTR,
    S_WR,
    S_RD
  } state_e;

  state_e state_q, state_d;

  logic scl_s1_q, scl_s2_q;
  logic sda_s1_q, sda_s2_q, sda_dly_q;

  logic [AW-1:0] ptr_q;
  logic [CW-1:0] stage_q;
  logic [SW-1:0] snap_q;
  logic [CW-1:0] cfg_out_q;
  logic [7:0]    tx_data_q;
  logic          cfg_update_q;
  logic          wr_stb_q;
  logic [AW-1:0] wr_addr_q;
  logic          busy_q;
  logic          dirty_q;

  logic       start_c, stop_c;
  logic       ptr_rw_c;
  logic       ptr_ld_c, ptr_inc_c, stage_we_c, snap_ld_c, commit_c;
  logic [7:0] rd_byte_c;

  // Two-flop synchronizers; sda gets an extra delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      sda_dly_q <= 1'b1;
    end else begin
      scl_s1_q  <= scl;
      scl_s2_q  <= scl_s1_q;
      sda_s1_q  <= sda_i;
      sda_s2_q  <= sda_s1_q;
      sda_dly_q <= sda_s2_q;
    end
  end

  assign start_c  = scl_s2_q & sda_dly_q & ~sda_s2_q;
  assign stop_c   = scl_s2_q & ~sda_dly_q & sda_s2_q;
  assign ptr_rw_c = ({1'b0, ptr_q} < RO_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus conditions win over byte strobes; a concurrent byte is dropped.
  always_comb begin
    state_d    = state_q;
    ptr_ld_c   = 1'b0;
    ptr_inc_c  = 1'b0;
    stage_we_c = 1'b0;
    snap_ld_c  = 1'b0;
    commit_c   = 1'b0;
    if (start_c) begin
      state_d = S_DEV;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      commit_c = dirty_q;
    end else if (bus_ready && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_DEV: begin
          if (rx_ena) begin
            if (rx_data[0]) begin
              state_d   = S_RD;
              snap_ld_c = 1'b1;
            end else begin
              state_d = S_PTR;
            end
          end
        end
        S_PTR: begin
          if (rx_ena) begin
            ptr_ld_c = 1'b1;
            state_d  = S_WR;
          end
        end
        S_WR: begin
          if (rx_ena) begin
            stage_we_c = ptr_rw_c;
            ptr_inc_c  = 1'b1;
          end
        end
        S_RD: begin
          if (tx_rdreq && !rx_ena) begin
            ptr_inc_c = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Read mux: RW indices come from the staging bank, RO indices from the snapshot.
  always_comb begin
    rd_byte_c = 8'h00;
    for (int unsigned i = 0; i < RO_BASE; i++) begin
      if (ptr_q == AW'(i)) rd_byte_c = stage_q[8*i +: 8];
    end
    for (int unsigned j = 0; j < NSTAT; j++) begin
      if (ptr_q == AW'(RO_BASE + j)) rd_byte_c = snap_q[8*j +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      stage_q      <= '0;
      snap_q       <= '0;
      cfg_out_q    <= '0;
      tx_data_q    <= 8'h00;
      cfg_update_q <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= '0;
      busy_q       <= 1'b0;
      dirty_q      <= 1'b0;
    end else begin
      cfg_update_q <= commit_c;
      wr_stb_q     <= stage_we_c;
      busy_q       <= (state_d != S_IDLE);
      tx_data_q    <= rd_byte_c;
      if (commit_c) begin
        cfg_out_q <= stage_q;
        dirty_q   <= 1'b0;
      end
      if (stage_we_c) begin
        for (int unsigned i = 0; i < RO_BASE; i++) begin
          if (ptr_q == AW'(i)) stage_q[8*i +: 8] <= rx_data;
        end
        wr_addr_q <= ptr_q;
        dirty_q   <= 1'b1;
      end
      if (snap_ld_c) begin
        snap_q <= status_in;
      end
      if (ptr_ld_c) begin
        ptr_q <= rx_data[AW-1:0];
      end else if (ptr_inc_c) begin
        ptr_q <= ptr_q + AW'(1);
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign cfg_out    = cfg_out_q;
  assign cfg_update = cfg_update_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign busy       = busy_q;

endmodule

// File: doc/i2c_reg_bridge.md
I2C_REG_BRIDGE -- requirements
Module: i2c_reg_bridge

Interface
REQ-001 Parameter: NREG, 16, register count (power of two, 4..256); AW = log2(NREG).
REQ-002 Parameter: RO_BASE, 12, first read-only index; indices 0..RO_BASE-1 are RW config, RO_BASE..NREG-1 are RO status.
REQ-003 Port: clk  in  1  single clock domain for all logic.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: scl, sda_i  in  1 each  raw I2C lines, monitored only.
REQ-006 Port: rx_data  in  8  byte from the I2C slave; valid when rx_ena=1.
REQ-007 Port: rx_ena  in  1  one-cycle strobe per received byte, including the device-address byte.
REQ-008 Port: bus_ready  in  1  high when the slave has no transfer in progress.
REQ-009 Port: tx_data  out  8  byte offered to the slave for read transfers.
REQ-010 Port: tx_rdreq  in  1  one-cycle strobe: the slave consumed tx_data.
REQ-011 Port: cfg_out  out  RO_BASE*8  committed RW registers; register i at bits [8i+7:8i].
REQ-012 Port: status_in  in  (NREG-RO_BASE)*8  live RO values, same packing.
REQ-013 Port: cfg_update  out  1  one-cycle pulse when cfg_out changes.
REQ-014 Port: wr_stb, wr_addr  out  1, AW  one-cycle pulse and index for each accepted staged write.
REQ-015 Port: busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 scl and sda_i SHALL pass through two synchronizer flops, then one delay flop. START = synced scl high and sda falling. STOP = synced scl high and sda rising.
REQ-017 FSM states: IDLE, DEV, PTR, WR, RD. Encoding is free.
REQ-018 START detected in any state SHALL go to DEV. This covers repeated start. Staged data and ptr are kept.
REQ-019 STOP detected in any state SHALL go to IDLE and trigger a commit (REQ-025).
REQ-020 DEV, rx_ena: if rx_data[0]=1, go to RD and latch status_in into a status snapshot. Otherwise go to PTR.
REQ-021 PTR, rx_ena: ptr <= rx_data[AW-1:0] (upper bits ignored); go to WR.
REQ-022 WR, rx_ena: if ptr < RO_BASE, stage[ptr] <= rx_data and pulse wr_stb with wr_addr=ptr in the following cycle. ptr then increments. Writes to RO indices are dropped with no wr_stb, but ptr still increments.
REQ-023 RD, tx_rdreq: ptr increments. This includes the final NACKed byte.
REQ-024 ptr SHALL wrap from NREG-1 to 0.
REQ-025 Commit: if at least one staged write occurred since the last commit, cfg_out <= stage and cfg_update pulses in the cycle after the STOP detect. Otherwise there is no pulse.
REQ-026 tx_data SHALL be registered every cycle from ptr. Source is stage[ptr] for RW indices and the snapshot for RO indices. Latency is 1 clk after a ptr change.
REQ-027 Simultaneous events, in priority order:
  - START/STOP over rx_ena/tx_rdreq; the concurrent byte is ignored.
  - rx_ena over tx_rdreq.
REQ-028 bus_ready=1 while not IDLE SHALL force IDLE with no commit.
REQ-029 rx_ena in IDLE and tx_rdreq outside RD SHALL be ignored.

Reset
REQ-030 With rst asserted, all of the following SHALL clear, asynchronously:
  - state = IDLE
  - ptr, stage, snapshot, cfg_out, tx_data all 0
  - cfg_update, wr_stb, wr_addr, busy all 0
  - synchronizer flops 1
REQ-031 Reset asserted mid-transfer SHALL discard uncommitted writes. After release the block waits for the next START.

Verification
REQ-032 START, rx 0xA4 (write), 0x03, 0x11, 0x22, STOP -> wr_stb at addr 3 then 4; cfg_out reg3=0x11, reg4=0x22; one cfg_update pulse.
REQ-033 START, rx 0xA4, 0x0B, 0x55, 0x66, STOP with RO_BASE=12 -> reg11=0x55; only one wr_stb; ptr=13; cfg_update pulses.
REQ-034 Write ptr 0x0E, repeated START, rx 0xA5, status_in reg14=0x9C/reg15=0x3D, three tx_rdreq -> tx_data 0x9C, 0x3D, reg0 (wrap); status change mid-read does not alter returned bytes.
REQ-035 START and rx_ena in the same cycle -> byte ignored, state DEV; STOP with no writes -> IDLE, no cfg_update.
REQ-036 Staged writes to reg2=0x77, then rst asserted before STOP -> cfg_out reg2 stays 0, no cfg_update, busy=0.
